chan_sel_mux_reg: RTL

//  Parametrised N-channel, W-bit registered selector; the next generation of the flat 8:1 x 32b datapath mux.

---
 rtl/chan_mux_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/chan_sel_mux_reg.sv | 93 +++++++++
 3 files changed

// File: rtl/chan_mux_pkg.sv
// Shared types and default sizing for the registered channel selector.
package chan_mux_pkg;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_RR     = 1'b1
  } sel_mode_t;

  localparam int unsigned CM_WIDTH = 32;
  localparam int unsigned CM_NCH   = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority encoder: the first requester after ptr wins, wrapping around.
module rr_arbiter #(
  parameter int unsigned NCH = 8
) (
  input  logic [NCH-1:0]         req,
  input  logic [$clog2(NCH)-1:0] ptr,
  output logic [$clog2(NCH)-1:0] grant,
  output logic                   gnt_vld
);

  localparam int unsigned SELW = $clog2(NCH);

  int unsigned idx;

  // Walk from farthest to nearest so the nearest requester after ptr is written last.
  always_comb begin
    grant   = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    for (int unsigned k = NCH; k >= 1; k--) begin
      idx = 32'(ptr) + k;
      if (idx >= NCH) begin
        idx = idx - NCH;
      end
      if (req[idx[SELW-1:0]]) begin
        grant   = idx[SELW-1:0];
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/chan_sel_mux_reg.sv
// N-channel registered selector with valid/ready handshake, direct or round-robin selection,
// and a one-entry output register.
module chan_sel_mux_reg
  import chan_mux_pkg::*;
#(
  parameter int unsigned WIDTH = CM_WIDTH,
  parameter int unsigned NCH   = CM_NCH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mode,
  input  logic [$clog2(NCH)-1:0] sel,
  input  logic [NCH-1:0]         in_valid,
  input  logic [NCH*WIDTH-1:0]   in_data,
  output logic [NCH-1:0]         in_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic [$clog2(NCH)-1:0] out_ch,
  input  logic                   out_ready
);

  localparam int unsigned SELW = $clog2(NCH);

  sel_mode_t        mode_e;
  logic [SELW-1:0]  rr_ptr_q;
  logic [SELW-1:0]  rr_grant;
  logic             rr_gnt_vld;
  logic [SELW-1:0]  grant;
  logic             gnt_vld;
  logic             sel_in_range;
  logic             load_en;
  logic             xfer;
  logic [WIDTH-1:0] grant_data;

  assign mode_e = sel_mode_t'(mode);

  rr_arbiter #(
    .NCH (NCH)
  ) u_rr_arbiter (
    .req     (in_valid),
    .ptr     (rr_ptr_q),
    .grant   (rr_grant),
    .gnt_vld (rr_gnt_vld)
  );

  // sel can exceed NCH-1 when NCH is not a power of two; such a select grants nothing.
  assign sel_in_range = (32'(sel) < NCH);

  always_comb begin
    grant   = '0;
    gnt_vld = 1'b0;
    if (mode_e == MODE_RR) begin
      grant   = rr_grant;
      gnt_vld = rr_gnt_vld;
    end else begin
      grant   = sel;
      gnt_vld = sel_in_range & in_valid[sel_in_range ? sel : '0];
    end
  end

  assign load_en = ~out_valid | out_ready;
  assign xfer    = ~reset & load_en & gnt_vld;

  always_comb begin
    in_ready   = '0;
    grant_data = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (grant == SELW'(i)) begin
        in_ready[i] = xfer;
        grant_data  = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr_q  <= SELW'(NCH - 1);
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= grant_data;
      out_ch    <= grant;
      if (mode_e == MODE_RR) begin
        rr_ptr_q <= grant;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
